ram_arbiter: RTL

//  Two-requester arbiter/sequencer for the single-port 16x16 RAM with cs/we/oe and a shared tristate data bus.

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_if
// Brief    : Client-side command/response bundle for the two-requester RAM
//            arbiter. Clients sit on the master modport, the arbiter on the
//            slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    // Client 0 command and response
    logic                  r0_req;
    logic                  r0_we;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_ack;
    logic                  r0_done;

    // Client 1 command and response
    logic                  r1_req;
    logic                  r1_we;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_ack;
    logic                  r1_done;

    // Shared status
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r0_ack, r0_done, r1_ack, r1_done, rdata, busy
    );

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r0_ack, r0_done, r1_ack, r1_done, rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-requester arbiter/sequencer for a single-port cs/we/oe RAM
//            with a shared tristate data bus. One access every three cycles:
//            IDLE -> ACCESS -> DONE -> IDLE. Sole driver of the RAM pins.
//            Optional macro ARB_FIXED_PRIO_EN: client 0 always wins ties;
//            otherwise ties are resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    ram_arbiter_if.slave               bus,
    output logic      [ADDR_WIDTH-1:0] mem_addr,
    output logic                       mem_cs,
    output logic                       mem_we,
    output logic                       mem_oe,
    inout  wire logic [DATA_WIDTH-1:0] mem_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_winner;      // 0 = client 0, 1 = client 1
    logic                  r_we_lat;
    logic [DATA_WIDTH-1:0] r_wdata_lat;

    logic                  w_any_req;
    logic                  w_pick1;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_drive;

    assign w_any_req = bus.r0_req | bus.r1_req;

`ifdef ARB_FIXED_PRIO_EN
    // Client 1 only wins when client 0 is not asking
    assign w_pick1 = bus.r1_req & ~bus.r0_req;
`else
    logic r_last_grant;

    // Remember who was granted last; reset favours client 0 on the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_grant <= w_pick1;
        end
    end

    // On a tie, the client that was not granted last wins
    assign w_pick1 = bus.r1_req & (~bus.r0_req | ~r_last_grant);
`endif

    // Select the winning client's command fields
    always_comb begin
        w_sel_we    = bus.r0_we;
        w_sel_addr  = bus.r0_addr;
        w_sel_wdata = bus.r0_wdata;
        if (w_pick1) begin
            w_sel_we    = bus.r1_we;
            w_sel_addr  = bus.r1_addr;
            w_sel_wdata = bus.r1_wdata;
        end
    end

    // Next-state decode; requests only matter in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State register, command latch and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_winner    <= 1'b0;
            r_we_lat    <= 1'b0;
            r_wdata_lat <= '0;
            mem_addr    <= '0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            bus.r0_ack  <= 1'b0;
            bus.r1_ack  <= 1'b0;
            bus.r0_done <= 1'b0;
            bus.r1_done <= 1'b0;
            bus.rdata   <= '0;
            bus.busy    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            bus.busy    <= (w_state_next != S_IDLE);
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            bus.r0_ack  <= 1'b0;
            bus.r1_ack  <= 1'b0;
            bus.r0_done <= 1'b0;
            bus.r1_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_winner    <= w_pick1;
                        r_we_lat    <= w_sel_we;
                        r_wdata_lat <= w_sel_wdata;
                        mem_addr    <= w_sel_addr;
                        mem_cs      <= 1'b1;
                        mem_we      <= w_sel_we;
                        mem_oe      <= ~w_sel_we;
                        bus.r0_ack  <= ~w_pick1;
                        bus.r1_ack  <= w_pick1;
                    end
                end
                S_ACCESS: begin
                    // The RAM has driven the bus since the mid-cycle negedge
                    if (!r_we_lat) begin
                        bus.rdata <= mem_data;
                    end
                    bus.r0_done <= ~r_winner;
                    bus.r1_done <= r_winner;
                end
                default: begin
                end
            endcase
        end
    end

    // Bus is ours only while a write is in ACCESS
    assign w_drive  = (r_state == S_ACCESS) && r_we_lat;
    assign mem_data = w_drive ? r_wdata_lat : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire
